// File: rtl/mem_ctrl_burst.sv
// mem_ctrl_burst: arbitrates the instruction-fetch and load/store channels
// onto one byte-serial RAM port. IF grants fetch a full line; LSB grants
// perform byte/half/word loads (with extension) or stores. Round-robin
// fairness, IO-aware store gating, pause/re-issue on rdy and flush handling.
module mem_ctrl_burst #(
    parameter int unsigned IF_LINE_BYTES = 4,
    parameter int unsigned ROB_WIDTH     = 4,
    parameter logic [31:0] IO_ADDR_MASK  = 32'h0003_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       io_buffer_full,
    input  logic                       flush,
    input  logic [7:0]                 mem_din,
    output logic [7:0]                 mem_dout,
    output logic [31:0]                mem_a,
    output logic                       mem_wr,
    input  logic                       if_req,
    input  logic [31:0]                if_addr,
    output logic                       if_done,
    output logic [8*IF_LINE_BYTES-1:0] if_line,
    input  logic                       lsb_req,
    input  logic                       lsb_store,
    input  logic [1:0]                 lsb_width,
    input  logic                       lsb_signed,
    input  logic [31:0]                lsb_addr,
    input  logic [31:0]                lsb_val,
    input  logic [ROB_WIDTH-1:0]       lsb_rob_id,
    output logic                       lsb_done,
    output logic                       ld_valid,
    output logic [31:0]                ld_val,
    output logic [ROB_WIDTH-1:0]       ld_rob_id
);

    localparam int unsigned CNT_W = $clog2(IF_LINE_BYTES) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IF_RD = 2'd1;
    localparam logic [1:0] ST_LS_RD = 2'd2;
    localparam logic [1:0] ST_LS_WR = 2'd3;

    // Sign/zero extension of a little-endian load of 1, 2 or 4 bytes.
    function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                                input logic [1:0]  width,
                                                input logic        sgn);
        logic [31:0] res;
        case (width)
            2'd0:    res = {{24{sgn & raw[7]}}, raw[7:0]};
            2'd1:    res = {{16{sgn & raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // IO region test: every mask bit must be set in the address.
    function automatic logic addr_is_io(input logic [31:0] addr);
        return ((addr & IO_ADDR_MASK) == IO_ADDR_MASK);
    endfunction

    logic [1:0]                 state_r;
    logic                       last_lsb_r;      // 1 = LSB was granted most recently
    logic [31:0]                addr_r;
    logic [1:0]                 width_r;
    logic                       signed_r;
    logic [31:0]                val_r;
    logic [ROB_WIDTH-1:0]       rob_r;
    logic                       io_r;
    logic [CNT_W-1:0]           nbytes_r;
    logic [CNT_W-1:0]           iss_r;           // bytes whose address has been issued
    logic [CNT_W-1:0]           cap_r;           // bytes captured (reads)
    logic                       addr_valid_r;    // mem_a this cycle is a live read address
    logic                       data_valid_r;    // mem_din this cycle belongs to byte cap_r
    logic [8*IF_LINE_BYTES-1:0] line_buf_r;

    logic                       if_pend_s;
    logic                       lsb_pend_s;
    logic                       grant_if_s;
    logic                       grant_lsb_s;
    logic [CNT_W-1:0]           lsb_n_s;
    logic                       last_byte_s;
    logic [31:0]                iss_addr_s;
    logic [7:0]                 wr_byte_s;
    logic [8*IF_LINE_BYTES-1:0] cap_line_s;

    // Arbitration: a channel's request is masked in its own done cycle; ties go round-robin.
    always_comb begin
        if_pend_s   = if_req  & ~if_done;
        lsb_pend_s  = lsb_req & ~lsb_done;
        grant_if_s  = 1'b0;
        grant_lsb_s = 1'b0;
        if (if_pend_s && lsb_pend_s) begin
            if (last_lsb_r) begin
                grant_if_s = 1'b1;
            end else begin
                grant_lsb_s = 1'b1;
            end
        end else if (lsb_pend_s) begin
            grant_lsb_s = 1'b1;
        end else if (if_pend_s) begin
            grant_if_s = 1'b1;
        end else begin
            grant_if_s  = 1'b0;
            grant_lsb_s = 1'b0;
        end
    end

    // Burst length, next issue address, outgoing store byte and last-capture flag.
    always_comb begin
        case (lsb_width)
            2'd0:    lsb_n_s = CNT_W'(1);
            2'd1:    lsb_n_s = CNT_W'(2);
            default: lsb_n_s = CNT_W'(4);
        endcase
        iss_addr_s  = addr_r + {{(32-CNT_W){1'b0}}, iss_r};
        last_byte_s = ((cap_r + CNT_W'(1)) == nbytes_r);
        case (iss_r[1:0])
            2'd0:    wr_byte_s = val_r[7:0];
            2'd1:    wr_byte_s = val_r[15:8];
            2'd2:    wr_byte_s = val_r[23:16];
            default: wr_byte_s = val_r[31:24];
        endcase
    end

    // Line buffer with the byte arriving on mem_din merged in at slot cap_r.
    always_comb begin
        cap_line_s = line_buf_r;
        for (int i = 0; i < int'(IF_LINE_BYTES); i++) begin
            if (cap_r == CNT_W'(i)) begin
                cap_line_s[8*i +: 8] = mem_din;
            end else begin
                cap_line_s[8*i +: 8] = line_buf_r[8*i +: 8];
            end
        end
    end

    // Main controller: grant, read pipeline with pause/re-issue, store sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_lsb_r   <= 1'b0;
            addr_r       <= 32'h0;
            width_r      <= 2'd0;
            signed_r     <= 1'b0;
            val_r        <= 32'h0;
            rob_r        <= '0;
            io_r         <= 1'b0;
            nbytes_r     <= '0;
            iss_r        <= '0;
            cap_r        <= '0;
            addr_valid_r <= 1'b0;
            data_valid_r <= 1'b0;
            line_buf_r   <= '0;
            mem_a        <= 32'h0;
            mem_wr       <= 1'b0;
            mem_dout     <= 8'h00;
            if_done      <= 1'b0;
            if_line      <= '0;
            lsb_done     <= 1'b0;
            ld_valid     <= 1'b0;
            ld_val       <= 32'h0;
            ld_rob_id    <= '0;
        end else begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            ld_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    mem_a        <= 32'h0;
                    mem_wr       <= 1'b0;
                    mem_dout     <= 8'h00;
                    addr_valid_r <= 1'b0;
                    data_valid_r <= 1'b0;
                    iss_r        <= '0;
                    cap_r        <= '0;
                    if (!flush && rdy && grant_lsb_s) begin
                        last_lsb_r <= 1'b1;
                        addr_r     <= lsb_addr;
                        width_r    <= lsb_width;
                        signed_r   <= lsb_signed;
                        val_r      <= lsb_val;
                        rob_r      <= lsb_rob_id;
                        io_r       <= addr_is_io(lsb_addr);
                        nbytes_r   <= lsb_n_s;
                        line_buf_r <= '0;
                        if (lsb_store) begin
                            state_r <= ST_LS_WR;
                            if (!(addr_is_io(lsb_addr) && io_buffer_full)) begin
                                mem_wr   <= 1'b1;
                                mem_a    <= lsb_addr;
                                mem_dout <= lsb_val[7:0];
                                iss_r    <= CNT_W'(1);
                            end
                        end else begin
                            state_r      <= ST_LS_RD;
                            mem_a        <= lsb_addr;
                            addr_valid_r <= 1'b1;
                            iss_r        <= CNT_W'(1);
                        end
                    end else if (!flush && rdy && grant_if_s) begin
                        last_lsb_r   <= 1'b0;
                        state_r      <= ST_IF_RD;
                        addr_r       <= if_addr;
                        io_r         <= 1'b0;
                        nbytes_r     <= CNT_W'(IF_LINE_BYTES);
                        line_buf_r   <= '0;
                        mem_a        <= if_addr;
                        addr_valid_r <= 1'b1;
                        iss_r        <= CNT_W'(1);
                    end
                end
                ST_IF_RD, ST_LS_RD: begin
                    if (flush) begin
                        // Speculative read is abandoned; partial data is dropped.
                        state_r      <= ST_IDLE;
                        mem_a        <= 32'h0;
                        addr_valid_r <= 1'b0;
                        data_valid_r <= 1'b0;
                    end else if (!rdy && !io_r) begin
                        // Drop anything in flight and rewind to the oldest uncaptured byte.
                        iss_r        <= cap_r;
                        addr_valid_r <= 1'b0;
                        data_valid_r <= 1'b0;
                    end else if (data_valid_r && last_byte_s) begin
                        state_r      <= ST_IDLE;
                        mem_a        <= 32'h0;
                        addr_valid_r <= 1'b0;
                        data_valid_r <= 1'b0;
                        line_buf_r   <= cap_line_s;
                        if (state_r == ST_IF_RD) begin
                            if_done <= 1'b1;
                            if_line <= cap_line_s;
                        end else begin
                            lsb_done  <= 1'b1;
                            ld_valid  <= 1'b1;
                            ld_val    <= load_extend(cap_line_s[31:0], width_r, signed_r);
                            ld_rob_id <= rob_r;
                        end
                    end else begin
                        // IO loads keep draining in-flight bytes while paused, never re-reading.
                        data_valid_r <= addr_valid_r;
                        if (data_valid_r) begin
                            line_buf_r <= cap_line_s;
                            cap_r      <= cap_r + CNT_W'(1);
                        end
                        if (rdy && (iss_r < nbytes_r)) begin
                            mem_a        <= iss_addr_s;
                            addr_valid_r <= 1'b1;
                            iss_r        <= iss_r + CNT_W'(1);
                        end else begin
                            addr_valid_r <= 1'b0;
                        end
                    end
                end
                ST_LS_WR: begin
                    // Stores are committed, so flush does not stop them.
                    if (!rdy) begin
                        mem_wr <= 1'b0;
                    end else if ((iss_r == '0) && io_r && io_buffer_full) begin
                        mem_wr <= 1'b0;
                    end else if (iss_r < nbytes_r) begin
                        mem_wr   <= 1'b1;
                        mem_a    <= iss_addr_s;
                        mem_dout <= wr_byte_s;
                        iss_r    <= iss_r + CNT_W'(1);
                    end else begin
                        state_r  <= ST_IDLE;
                        mem_wr   <= 1'b0;
                        mem_a    <= 32'h0;
                        mem_dout <= 8'h00;
                        lsb_done <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl_burst.sv
// Directed bench for mem_ctrl_burst with a byte RAM model driven from the
// stimulus thread. Inputs change and outputs are read 1 time unit after
// each rising edge, so each step() advances exactly one controller cycle.
module tb_mem_ctrl_burst;

    logic        clk = 1'b0;
    logic        rst, rdy, io_buffer_full, flush;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_line;
    logic        lsb_req, lsb_store, lsb_signed;
    logic [1:0]  lsb_width;
    logic [31:0] lsb_addr, lsb_val;
    logic [3:0]  lsb_rob_id;
    logic        lsb_done, ld_valid;
    logic [31:0] ld_val;
    logic [3:0]  ld_rob_id;

    logic [7:0]  ram [0:65535];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] word;

    always #5 clk = ~clk;

    mem_ctrl_burst #(.IF_LINE_BYTES(4), .ROB_WIDTH(4), .IO_ADDR_MASK(32'h0003_0000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .io_buffer_full(io_buffer_full), .flush(flush),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_line(if_line),
        .lsb_req(lsb_req), .lsb_store(lsb_store), .lsb_width(lsb_width),
        .lsb_signed(lsb_signed), .lsb_addr(lsb_addr), .lsb_val(lsb_val),
        .lsb_rob_id(lsb_rob_id), .lsb_done(lsb_done), .ld_valid(ld_valid),
        .ld_val(ld_val), .ld_rob_id(ld_rob_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: RAM writes the byte presented this cycle and returns the
    // byte at this cycle's address on mem_din in the next cycle.
    task automatic step();
        logic [31:0] a;
        logic        w;
        logic [7:0]  d;
        a = mem_a;
        w = mem_wr;
        d = mem_dout;
        @(posedge clk);
        #1;
        if (w === 1'b1) ram[a[15:0]] = d;
        mem_din = ram[a[15:0]];
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic lsb_go(input logic st, input logic [1:0] w, input logic sg,
                          input logic [31:0] a, input logic [31:0] v, input logic [3:0] rob);
        lsb_req = 1'b1; lsb_store = st; lsb_width = w; lsb_signed = sg;
        lsb_addr = a; lsb_val = v; lsb_rob_id = rob;
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0; mem_din = 8'h00;
        if_req = 1'b0; if_addr = 32'h0;
        lsb_req = 1'b0; lsb_store = 1'b0; lsb_width = 2'd0; lsb_signed = 1'b0;
        lsb_addr = 32'h0; lsb_val = 32'h0; lsb_rob_id = 4'd0;
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13;
        ram[16'h0020] = 8'h80;
        ram[16'h0022] = 8'h34; ram[16'h0023] = 8'h92;
        ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h84;

        // Reset state
        steps(2);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_dout", mem_dout, 8'h00);
        chk("rst_pulses", {if_done, lsb_done, ld_valid}, 3'b000);
        chk("rst_if_line", if_line, 32'h0);
        chk("rst_ld", {ld_val, ld_rob_id}, 36'h0);
        rst = 1'b0;
        step();

        // IF line read at 0x1000
        if_req = 1'b1; if_addr = 32'h0000_1000;
        for (int c = 1; c <= 6; c++) begin
            step();
            if (c <= 4) chk("if_mem_a", mem_a, 32'h0000_1000 + 32'(c - 1));
            chk("if_done_timing", if_done, (c == 6));
            chk("if_no_lsb_pulse", {lsb_done, ld_valid}, 2'b00);
        end
        chk("if_line", if_line, 32'h0000_0013);
        if_req = 1'b0;
        step();

        // LB signed at 0x20, fields changed after grant
        lsb_go(1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 4'd5);
        step();
        chk("lb_mem_a", mem_a, 32'h20);
        lsb_addr = 32'hFFFF_FFF0; lsb_rob_id = 4'd0; lsb_signed = 1'b0;
        step();
        chk("lb_early", ld_valid, 1'b0);
        step();
        chk("lb_pulses", {ld_valid, lsb_done}, 2'b11);
        chk("lb_val", ld_val, 32'hFFFF_FF80);
        chk("lb_rob", ld_rob_id, 4'd5);
        lsb_req = 1'b0;
        step();

        // LHU at 0x22
        lsb_go(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 4'd3);
        step();
        chk("lhu_a0", mem_a, 32'h22);
        step();
        chk("lhu_a1", mem_a, 32'h23);
        step();
        chk("lhu_early", ld_valid, 1'b0);
        step();
        chk("lhu_valid", ld_valid, 1'b1);
        chk("lhu_val", ld_val, 32'h0000_9234);
        lsb_req = 1'b0;
        step();

        // LH signed at 0x22
        lsb_go(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, 4'd4);
        steps(4);
        chk("lh_valid", ld_valid, 1'b1);
        chk("lh_val", ld_val, 32'hFFFF_9234);
        lsb_req = 1'b0;
        step();

        // Fresh reset so LSB is favoured, then a simultaneous pair
        rst = 1'b1; step(); rst = 1'b0; step();
        if_req = 1'b1; if_addr = 32'h0000_1000;
        lsb_go(1'b1, 2'd2, 1'b0, 32'h40, 32'hDEAD_BEEF, 4'd0);
        word = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("sw_wr", mem_wr, 1'b1);
            chk("sw_a", mem_a, 32'h40 + 32'(c - 1));
            chk("sw_dout", mem_dout, word[8*(c-1) +: 8]);
        end
        step();
        chk("sw_done", lsb_done, 1'b1);
        lsb_req = 1'b0;
        step();
        chk("pair_if_next", {mem_wr, mem_a}, {1'b0, 32'h0000_1000});
        steps(5);
        chk("pair_if_done", if_done, 1'b1);
        chk("pair_if_line", if_line, 32'h0000_0013);
        if_req = 1'b0;
        step();
        chk("sw_ram", {ram[16'h43], ram[16'h42], ram[16'h41], ram[16'h40]}, 32'hDEAD_BEEF);

        // LSB-only load, so the next tie goes to IF
        lsb_go(1'b0, 2'd0, 1'b0, 32'h41, 32'h0, 4'd1);
        steps(3);
        chk("lbu_val", {ld_valid, ld_val}, {1'b1, 32'h0000_00BE});
        lsb_req = 1'b0;
        step();
        if_req = 1'b1; if_addr = 32'h0000_1000;
        lsb_go(1'b0, 2'd0, 1'b1, 32'h40, 32'h0, 4'd7);
        step();
        chk("pair2_if_first", mem_a, 32'h0000_1000);
        steps(5);
        chk("pair2_if_done", if_done, 1'b1);
        if_req = 1'b0;
        step();
        chk("pair2_lsb_next", mem_a, 32'h40);
        steps(2);
        chk("pair2_ld", {ld_valid, ld_val, ld_rob_id}, {1'b1, 32'hFFFF_FFEF, 4'd7});
        lsb_req = 1'b0;
        step();

        // Non-IO store ignores io_buffer_full
        io_buffer_full = 1'b1;
        lsb_go(1'b1, 2'd0, 1'b0, 32'h50, 32'h55, 4'd0);
        step();
        chk("nonio_wr", {mem_wr, mem_a}, {1'b1, 32'h50});
        step();
        chk("nonio_done", lsb_done, 1'b1);
        lsb_req = 1'b0;
        step();

        // IO store held back while the buffer is full
        lsb_go(1'b1, 2'd0, 1'b0, 32'h0003_0000, 32'h41, 4'd0);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("io_stall", mem_wr, 1'b0);
        end
        io_buffer_full = 1'b0;
        step();
        chk("io_write", {mem_wr, mem_a, mem_dout}, {1'b1, 32'h0003_0000, 8'h41});
        step();
        chk("io_done", lsb_done, 1'b1);
        lsb_req = 1'b0;
        step();

        // Flush during the third IF byte
        if_req = 1'b1; if_addr = 32'h0000_1000;
        steps(3);
        chk("fl_if_a", mem_a, 32'h0000_1002);
        flush = 1'b1; if_req = 1'b0;
        step();
        flush = 1'b0;
        chk("fl_if_idle", {mem_wr, mem_a}, 33'h0);
        for (int c = 4; c <= 8; c++) begin
            chk("fl_if_no_done", if_done, 1'b0);
            step();
        end

        // Flush during SW byte 1 does not stop the store
        lsb_go(1'b1, 2'd2, 1'b0, 32'h60, 32'hCAFE_F00D, 4'd0);
        steps(2);
        chk("fl_sw_a1", mem_a, 32'h61);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_sw_a2", {mem_wr, mem_a}, {1'b1, 32'h62});
        steps(2);
        chk("fl_sw_done", lsb_done, 1'b1);
        lsb_req = 1'b0;
        step();
        chk("fl_sw_ram", {ram[16'h63], ram[16'h62], ram[16'h61], ram[16'h60]}, 32'hCAFE_F00D);

        // rdy pause mid LW, byte 1 re-issued
        lsb_go(1'b0, 2'd2, 1'b1, 32'h100, 32'h0, 4'd9);
        step();
        chk("rdy_a0", mem_a, 32'h100);
        step();
        chk("rdy_a1", mem_a, 32'h101);
        step();
        rdy = 1'b0;
        steps(3);
        rdy = 1'b1;
        step();
        chk("rdy_reissue", mem_a, 32'h101);
        step();
        chk("rdy_a2", mem_a, 32'h102);
        step();
        chk("rdy_a3", mem_a, 32'h103);
        chk("rdy_early", ld_valid, 1'b0);
        step();
        chk("rdy_early2", ld_valid, 1'b0);
        step();
        chk("rdy_ld", {ld_valid, lsb_done, ld_val, ld_rob_id}, {2'b11, 32'h8433_2211, 4'd9});
        lsb_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
